// File: rtl/ysyx_220066_ifu.sv
// ysyx_220066_ifu: instruction fetch stage with a one-outstanding-request memory port and a small fetch buffer.
module ysyx_220066_ifu #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        block,
    output logic        valid_out,
    output logic [31:0] instr,
    output logic [63:0] pc_out,
    output logic        instr_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_t;

    state_t        state;
    logic [63:0]   pc_reg, req_pc;
    logic [63:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic          fifo_err   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          not_full, misaligned, fire, push, pop;
    logic [63:0]   push_pc;
    logic [31:0]   push_instr;
    logic          push_err;

    always_comb begin
        not_full       = count < DEPTH;
        misaligned     = pc_reg[1:0] != 2'b00;
        imem_req_valid = rst && state == IDLE && not_full && !misaligned && !redirect_valid;
        imem_req_addr  = pc_reg;
        fire           = imem_req_valid && imem_req_ready;
        // A misaligned PC produces a fault entry instead of a memory request.
        push           = rst && !redirect_valid &&
                         ((state == WAIT && imem_resp_valid) || (state == IDLE && not_full && misaligned));
        push_pc        = state == WAIT ? req_pc : pc_reg;
        push_instr     = state == WAIT ? imem_resp_data : 32'h0;
        push_err       = state == WAIT ? imem_resp_err : 1'b1;
        valid_out      = count != '0;
        pop            = valid_out && !block && !redirect_valid;
        instr          = valid_out ? fifo_instr[rd_ptr] : 32'h0;
        pc_out         = valid_out ? fifo_pc[rd_ptr] : 64'h0;
        instr_error    = valid_out ? fifo_err[rd_ptr] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_instr[wr_ptr] <= push_instr;
            fifo_err[wr_ptr]   <= push_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            pc_reg <= RESET_PC;
            req_pc <= 64'h0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc_reg <= redirect_pc;
            // A response landing together with the redirect retires the outstanding request.
            state  <= (state == WAIT || state == DROP) && !imem_resp_valid ? DROP : IDLE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            case (state)
                IDLE: begin
                    if (fire) begin
                        req_pc <= pc_reg;
                        pc_reg <= pc_reg + 64'd4;
                        state  <= WAIT;
                    end else if (push) begin
                        state <= HALT;
                    end
                end
                WAIT: if (imem_resp_valid) state <= imem_resp_err ? HALT : IDLE;
                DROP: if (imem_resp_valid) state <= IDLE;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: doc/ysyx_220066_ifu.md
Name: ysyx_220066_ifu

Overview:
- Instruction-fetch stage of the RV64 in-order pipeline, directly upstream of the decode stage.
- Owns the architectural fetch PC and issues one 32-bit instruction-memory request at a time.
- Buffers returned instructions in a small FIFO and presents the FIFO head to decode as {valid, pc, instr, instr_error}, honouring decode's block stall.
- Squashes in-flight and buffered fetches on a redirect (branch, jump, trap, mret).

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, entries in the fetch buffer; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  fetch address; equals pc_reg.
- imem_resp_valid  in  1  response valid; arrives ≥1 cycle after request acceptance.
- imem_resp_data  in  32  fetched instruction.
- imem_resp_err  in  1  access fault for this fetch.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  64  new fetch PC.
- block  in  1  decode stall; head entry is not consumed.
- valid_out  out  1  FIFO non-empty.
- instr  out  32  head instruction.
- pc_out  out  64  head PC.
- instr_error  out  1  head entry faulted (misaligned or access fault).

Behaviour:
- Reset (rst=0 at posedge):
  - pc_reg=RESET_PC, FIFO empty, state=IDLE.
  - imem_req_valid=0, valid_out=0, instr=0, pc_out=0, instr_error=0.
  - Any pending response is ignored, including one arriving mid-reset.
- States:
  - IDLE: no request outstanding.
  - WAIT: request accepted, response pending.
  - DROP: request accepted but squashed, response pending.
  - HALT: fetch stopped after a fault entry.
- IDLE:
  - imem_req_valid = (count<FIFO_DEPTH) && pc_reg[1:0]==0 && ~redirect_valid.
  - On valid&&ready: req_pc<=pc_reg, pc_reg<=pc_reg+4 (64-bit wrap), go to WAIT.
  - If pc_reg[1:0]!=0 and count<FIFO_DEPTH: push {pc_reg, 32'h0, err=1}, no request issued, go to HALT.
- WAIT: on imem_resp_valid, push {req_pc, imem_resp_data, imem_resp_err}. Go to HALT if imem_resp_err, else IDLE.
- DROP: on imem_resp_valid, discard the response and go to IDLE.
- HALT: issue nothing; leave only on redirect.
- Space guarantee: a request issues only when count<FIFO_DEPTH, so a response push never overflows.
- Pop: when valid_out && ~block. A push and a pop in the same cycle leave count unchanged.
- Outputs instr/pc_out/instr_error are driven combinationally from the FIFO head; they are 0 when the FIFO is empty.
- Redirect (highest priority, that cycle):
  - FIFO cleared; any push and pop that cycle are suppressed; pc_reg<=redirect_pc.
  - WAIT→DROP, IDLE/HALT→IDLE, DROP stays DROP.
  - imem_req_valid is forced 0 that cycle; an unaccepted request is withdrawn.
  - A response arriving in the same cycle as a redirect is discarded.
  - The first request after a redirect issues no earlier than the next cycle.
- While a request is presented but not accepted, imem_req_addr is held stable.
- The FIFO uses wrap-around read/write pointers plus a count; full = count==FIFO_DEPTH.

Test Plan:
- Reset → first request at 0x80000000. With ready=1 and the response one cycle later carrying 0x00000013: valid_out=1, pc_out=0x80000000, instr=0x00000013, error=0. The next request is at 0x80000004.
- Hold block=1 across three fetches → FIFO fills to 2 and no third request issues. Release block → entries pop in order (0x80000000, 0x80000004), then fetch resumes at 0x80000008.
- Redirect to 0x80001000 while in WAIT → FIFO cleared the same cycle. The stale response is dropped, and the next request is at 0x80001000.
- Redirect to 0x80000002 → a single entry is produced with pc_out=0x80000002, instr_error=1, instr=0. No memory request issues until the next redirect.
- imem_resp_err=1 on the fetch of 0x80000010 → entry with instr_error=1, then HALT. A redirect to 0x80000100 resumes fetch.
- rst=0 asserted while in WAIT with two entries buffered → next cycle valid_out=0 and imem_req_valid=0. A late response is ignored, and after rst=1 the first request is at 0x80000000.
